// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Write-side controller for the FIFO storage array. It shares the single write
// port between two producers using round-robin arbitration. Once a producer wins,
// it keeps the port for up to MaxBurst consecutive beats. The block also owns the
// binary and Gray write pointers and the registered full flag.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | port is open; the grantee is picked from valids and rr_prio
// BUSY  | port is locked to r_owner until the burst ends or the owner drops
//
// Grant selection, readies and the array write are combinational. The array
// captures the word on the same wclk edge that accepts it. Readies are gated
// by wrst_n, so no word is taken while reset is asserted.

module fifo_wr_arbiter #(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 4,
    parameter int MaxBurst  = 4
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 req0_valid,
    input  logic [DataWidth-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DataWidth-1:0] req1_data,
    output logic                 req1_ready,
    input  logic [AddrWidth:0]   wq2_rptr,
    output logic                 mem_wclken,
    output logic [AddrWidth-1:0] mem_waddr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic [AddrWidth:0]   wptr,
    output logic                 wfull,
    output logic                 grant_id
);

    localparam int BeatWidth = $clog2(MaxBurst + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [BeatWidth-1:0] LP_BEAT_ONE = BeatWidth'(1);
    localparam logic [BeatWidth-1:0] LP_BEAT_MAX = BeatWidth'(MaxBurst);

    logic [AddrWidth:0]   r_wbin;
    logic [AddrWidth:0]   r_wptr;
    logic                 r_wfull;
    logic [0:0]           r_st;
    logic                 r_owner;
    logic                 r_rr_prio;
    logic [BeatWidth-1:0] r_beat;
    logic                 r_grant_id;

    logic                 w_grantee;
    logic                 w_ready0;
    logic                 w_ready1;
    logic                 w_accept;
    logic                 w_owner_valid;
    logic                 w_burst_last;
    logic [AddrWidth:0]   w_wbin_nxt;
    logic [AddrWidth:0]   w_wgray_nxt;
    logic [AddrWidth:0]   w_full_cmp;
    logic [DataWidth-1:0] w_wdata;

    // Grantee: the locked owner in BUSY; otherwise the only valid producer,
    // or rr_prio when both producers are valid.
    always_comb begin
        w_grantee = 1'b0;
        if (r_st == ST_BUSY) begin
            w_grantee = r_owner;
        end else if (req0_valid && req1_valid) begin
            w_grantee = r_rr_prio;
        end else if (req1_valid) begin
            w_grantee = 1'b1;
        end else begin
            w_grantee = 1'b0;
        end
    end

    // Readies, accept, write data and next-pointer arithmetic
    always_comb begin
        w_ready0      = wrst_n & ~r_wfull & req0_valid & ~w_grantee;
        w_ready1      = wrst_n & ~r_wfull & req1_valid &  w_grantee;
        w_accept      = w_ready0 | w_ready1;
        w_owner_valid = r_owner ? req1_valid : req0_valid;
        w_burst_last  = ((r_beat + LP_BEAT_ONE) == LP_BEAT_MAX);
        w_wdata       = w_grantee ? req1_data : req0_data;
        w_wbin_nxt    = r_wbin + {{AddrWidth{1'b0}}, w_accept};
        w_wgray_nxt   = w_wbin_nxt ^ (w_wbin_nxt >> 1);
        // The synchronized read pointer, moved half a wrap ahead in Gray code
        w_full_cmp    = {~wq2_rptr[AddrWidth:AddrWidth-1], wq2_rptr[AddrWidth-2:0]};
    end

    // Binary and Gray write pointers advance together on every accepted beat
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin <= '0;
            r_wptr <= '0;
        end else begin
            r_wbin <= w_wbin_nxt;
            r_wptr <= w_wgray_nxt;
        end
    end

    // Full flag, re-evaluated every cycle from the post-write pointer and the
    // current synchronized read pointer
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wfull <= 1'b0;
        end else begin
            r_wfull <= (w_wgray_nxt == w_full_cmp);
        end
    end

    // Arbitration FSM: burst locking, beat counting and round-robin priority
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_st      <= ST_IDLE;
            r_owner   <= 1'b0;
            r_rr_prio <= 1'b0;
            r_beat    <= '0;
        end else begin
            case (r_st)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner   <= w_grantee;
                        r_rr_prio <= ~w_grantee;
                        if (MaxBurst > 1) begin
                            r_st   <= ST_BUSY;
                            r_beat <= LP_BEAT_ONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_accept) begin
                        if (w_burst_last) begin
                            r_st   <= ST_IDLE;
                            r_beat <= '0;
                        end else begin
                            r_beat <= r_beat + LP_BEAT_ONE;
                        end
                    end else if (!w_owner_valid) begin
                        // The owner went away mid-burst: release the port and
                        // leave a one-cycle bubble
                        r_st   <= ST_IDLE;
                        r_beat <= '0;
                    end
                    // The owner is valid but the array is full: hold the burst
                end
                default: begin
                    r_st   <= ST_IDLE;
                    r_beat <= '0;
                end
            endcase
        end
    end

    // grant_id follows each new grant made from IDLE. In BUSY it already
    // equals the owner, so it simply holds.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_grant_id <= 1'b0;
        end else if ((r_st == ST_IDLE) && w_accept) begin
            r_grant_id <= w_grantee;
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign mem_wclken = w_accept;
    assign mem_waddr  = r_wbin[AddrWidth-1:0];
    assign mem_wdata  = w_wdata;
    assign wptr       = r_wptr;
    assign wfull      = r_wfull;
    assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter. Uses the default parameters: 8-bit words,
// a 16-deep array and bursts of up to 4 beats.
module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 16;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          req0_valid = 1'b0;
    logic [DW-1:0] req0_data = 8'h00;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [DW-1:0] req1_data = 8'h80;
    logic          req1_ready;
    logic [AW:0]   wq2_rptr = '0;
    logic          mem_wclken;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          grant_id;

    fifo_wr_arbiter #(.DataWidth(DW), .AddrWidth(AW), .MaxBurst(MB)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .wq2_rptr(wq2_rptr),
        .mem_wclken(mem_wclken), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wptr(wptr), .wfull(wfull), .grant_id(grant_id)
    );

    always #5 wclk = ~wclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: total words written, burst lock, priority, full flag
    int m_wcnt = 0;
    bit m_locked = 0;
    bit m_lock_id = 0;
    int m_beats = 0;
    bit m_prio = 0;
    bit m_gid = 0;
    bit m_full = 0;
    bit m_acc0 = 0;
    bit m_acc1 = 0;
    bit e_g, e_r0, e_r1, e_acc;

    // Observed DUT writes
    int n_writes = 0;
    bit gseq[$];
    logic [AW-1:0] aseq[$];

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] g2b(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare at the falling edge, then advance the model across the next rising edge
    initial begin
        forever begin
            @(negedge wclk);
            if (!wrst_n) begin
                m_wcnt = 0; m_locked = 0; m_lock_id = 0; m_beats = 0;
                m_prio = 0; m_gid = 0; m_full = 0; m_acc0 = 0; m_acc1 = 0;
                chk("rst_ready0", req0_ready, 0);
                chk("rst_ready1", req1_ready, 0);
                chk("rst_wclken", mem_wclken, 0);
                chk("rst_wptr", wptr, 0);
                chk("rst_wfull", wfull, 0);
                chk("rst_grant_id", grant_id, 0);
            end else begin
                e_g  = m_locked ? m_lock_id : ((req0_valid && req1_valid) ? m_prio : req1_valid);
                e_r0 = !e_g && req0_valid && !m_full;
                e_r1 =  e_g && req1_valid && !m_full;
                e_acc = e_r0 | e_r1;
                chk("ready0", req0_ready, e_r0);
                chk("ready1", req1_ready, e_r1);
                chk("wclken", mem_wclken, e_acc);
                chk("wptr", wptr, gray(5'(m_wcnt)));
                chk("wfull", wfull, m_full);
                chk("grant_id", grant_id, m_gid);
                if (e_acc) begin
                    chk("waddr", mem_waddr, m_wcnt % DEPTH);
                    chk("wdata", mem_wdata, e_g ? req1_data : req0_data);
                end
                if (mem_wclken === 1'b1) begin
                    n_writes++;
                    gseq.push_back(req1_ready);
                    aseq.push_back(mem_waddr);
                end
                m_acc0 = e_r0;
                m_acc1 = e_r1;
                if (e_acc) begin
                    m_wcnt = (m_wcnt + 1) % (2 * DEPTH);
                    if (!m_locked) begin
                        m_gid  = e_g;
                        m_prio = !e_g;
                        if (MB > 1) begin
                            m_locked = 1; m_lock_id = e_g; m_beats = 1;
                        end
                    end else begin
                        m_beats++;
                        if (m_beats == MB) begin
                            m_locked = 0; m_beats = 0;
                        end
                    end
                end else if (m_locked && !(m_lock_id ? req1_valid : req0_valid)) begin
                    m_locked = 0; m_beats = 0;
                end
                m_full = ((m_wcnt - int'(g2b(wq2_rptr)) + 2 * DEPTH) % (2 * DEPTH)) == DEPTH;
            end
        end
    end

    // Advance one clock; the producers move to the next word once theirs was taken
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge wclk);
            #1;
            if (m_acc0) req0_data = req0_data + 8'h01;
            if (m_acc1) req1_data = req1_data + 8'h01;
        end
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; wq2_rptr = '0;
        wrst_n = 0;
        tick(2);
        wrst_n = 1;
        gseq.delete(); aseq.delete(); n_writes = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1);
    end

    bit pat[12];
    int base;
    bit found;

    initial begin
        pat = '{0,0,0,0,1,1,1,1,0,0,0,0};

        // Reset with both producers valid, then release
        wrst_n = 0; req0_valid = 1; req1_valid = 1;
        tick(2);
        @(negedge wclk);
        chk("lit_rst_ready0", req0_ready, 0);
        chk("lit_rst_ready1", req1_ready, 0);
        chk("lit_rst_wclken", mem_wclken, 0);
        chk("lit_rst_wptr", wptr, 0);
        chk("lit_rst_wfull", wfull, 0);
        tick(1);
        wrst_n = 1;
        @(negedge wclk);
        chk("lit_first_grant_ready0", req0_ready, 1);
        chk("lit_first_grant_ready1", req1_ready, 0);
        chk("lit_first_waddr", mem_waddr, 0);

        // Fill from producer 0 with the read pointer parked at 0
        do_reset();
        req0_valid = 1;
        tick(20);
        @(negedge wclk);
        chk("lit_fill_writes", n_writes, 16);
        chk("lit_fill_wfull", wfull, 1);
        chk("lit_fill_wptr", wptr, 5'b11000);
        chk("lit_fill_ready0", req0_ready, 0);
        chk("lit_fill_last_addr", (aseq.size() == 16) ? aseq[15] : 4'hx, 15);

        // Contention while the read pointer keeps up
        do_reset();
        req0_valid = 1; req1_valid = 1;
        repeat (21) begin
            wq2_rptr = gray(5'(m_wcnt));
            tick(1);
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge wclk);
        chk("lit_cont_writes", gseq.size(), 21);
        if (gseq.size() >= 17) begin
            for (int i = 0; i < 12; i++) chk($sformatf("lit_cont_owner%0d", i), gseq[i], pat[i]);
            chk("lit_cont_addr15", aseq[15], 15);
            chk("lit_cont_wrap_addr", aseq[16], 0);
        end
        tick(1);

        // Owner drop: producer 1 leaves after two beats
        do_reset();
        req1_valid = 1;
        tick(2);
        req1_valid = 0; req0_valid = 1;
        @(negedge wclk);
        chk("lit_drop_bubble_wclken", mem_wclken, 0);
        chk("lit_drop_bubble_ready0", req0_ready, 0);
        tick(1);
        @(negedge wclk);
        chk("lit_drop_ready0", req0_ready, 1);
        tick(1);
        req0_valid = 0;
        @(negedge wclk);
        chk("lit_drop_grant_id", grant_id, 0);
        tick(1);
        req0_valid = 1; req1_valid = 1;
        @(negedge wclk);
        chk("lit_drop_tie_ready1", req1_ready, 1);
        chk("lit_drop_tie_ready0", req0_ready, 0);
        tick(1);

        // Full release: producer 1 stalls in a burst until the read pointer moves
        do_reset();
        req0_valid = 1;
        for (int i = 0; i < 40 && m_wcnt != 14; i++) tick(1);
        chk("lit_rel_prefill", n_writes, 14);
        req0_valid = 0; req1_valid = 1;
        tick(4);
        @(negedge wclk);
        chk("lit_rel_full", wfull, 1);
        chk("lit_rel_stall_ready1", req1_ready, 0);
        chk("lit_rel_grant_id", grant_id, 1);
        chk("lit_rel_writes", n_writes, 16);
        base = gseq.size();
        tick(1);
        wq2_rptr = 5'b00001;
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge wclk);
            if (mem_wclken === 1'b1) found = 1;
        end
        chk("lit_rel_write_seen", found, 1);
        chk("lit_rel_waddr", mem_waddr, 0);
        chk("lit_rel_owner", req1_ready, 1);
        tick(1);
        wq2_rptr = gray(5'd8);
        req0_valid = 1;
        tick(8);
        req0_valid = 0; req1_valid = 0;
        @(negedge wclk);
        chk("lit_rel_seq_len", gseq.size() >= base + 3, 1);
        if (gseq.size() >= base + 3) begin
            chk("lit_rel_seq0", gseq[base], 1);
            chk("lit_rel_seq1", gseq[base+1], 1);
            chk("lit_rel_seq2", gseq[base+2], 0);
        end
        tick(1);

        // Reset in the middle of a producer-1 burst
        do_reset();
        req1_valid = 1;
        tick(2);
        wrst_n = 0; req0_valid = 1; req1_valid = 1;
        @(negedge wclk);
        chk("lit_midrst_wptr", wptr, 0);
        chk("lit_midrst_ready1", req1_ready, 0);
        chk("lit_midrst_wclken", mem_wclken, 0);
        tick(1);
        wrst_n = 1;
        @(negedge wclk);
        chk("lit_midrst_tie_ready0", req0_ready, 1);
        chk("lit_midrst_tie_ready1", req1_ready, 0);
        chk("lit_midrst_waddr", mem_waddr, 0);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side controller for the FIFO storage array. Shares the array's single write port between two producers using round-robin arbitration with bounded burst locking.
- Owns the binary and Gray write pointers and generates the full flag. It compares against the read pointer already synchronized into the write domain, and drives the array's write enable, address and data.
- Sits in the write clock domain; it replaces the single-producer write-pointer/full logic.

Parameters:
- DataWidth, 8, word width of the producers and the array.
- AddrWidth, 4, array address width; depth = 2**AddrWidth.
- MaxBurst, 4, maximum consecutive beats granted to one producer before arbitration reopens (>=1).

Ports:
- wclk  input  1  write-domain clock, rising edge.
- wrst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  producer 0 has a word.
- req0_data  input  DataWidth  producer 0 word.
- req0_ready  output  1  producer 0 word accepted this cycle when valid&ready.
- req1_valid  input  1  producer 1 has a word.
- req1_data  input  DataWidth  producer 1 word.
- req1_ready  output  1  producer 1 word accepted this cycle when valid&ready.
- wq2_rptr  input  AddrWidth+1  Gray read pointer, already synchronized to wclk.
- mem_wclken  output  1  array write enable.
- mem_waddr  output  AddrWidth  array write address.
- mem_wdata  output  DataWidth  array write data.
- wptr  output  AddrWidth+1  registered Gray write pointer, for the read-domain synchronizer.
- wfull  output  1  registered full flag.
- grant_id  output  1  owner of the current or last grant.

Behaviour:
- State: wbin (AddrWidth+1), wptr, wfull, st in {IDLE, BUSY}, owner, rr_prio, beat (0..MaxBurst).
- Reset (async, while wrst_n=0):
  - wbin=0, wptr=0, wfull=0, st=IDLE, owner=0, rr_prio=0 (producer 0 favoured), beat=0, grant_id=0.
  - Both readies and mem_wclken forced 0.
- Grant selection (combinational):
  - IDLE, one valid: that producer is the grantee.
  - IDLE, both valid: the grantee is rr_prio.
  - BUSY: the grantee is owner only; the other producer is never ready.
- Ready and accept:
  - reqN_ready = (grantee==N) & reqN_valid & ~wfull.
  - accept = OR of valid&ready over both producers.
- Write (same cycle as accept):
  - mem_wclken = accept.
  - mem_waddr = wbin[AddrWidth-1:0].
  - mem_wdata = grantee data.
  - The array captures the word on that same wclk edge; zero added latency.
- Pointers: on accept, wbin += 1 and wptr = bin2gray(wbin+1). Both are AddrWidth+1 bits and wrap modulo 2**(AddrWidth+1).
- Full flag, registered every cycle:
  - wfull <= (bin2gray(wbin+accept) == {~wq2_rptr[AddrWidth:AddrWidth-1], wq2_rptr[AddrWidth-2:0]}).
  - wfull rises on the edge that writes the last free slot.
  - wfull falls one cycle after wq2_rptr advances.
- FSM transitions:
  - IDLE, accept, MaxBurst>1: go to BUSY; owner<=grantee, beat<=1, rr_prio<=~grantee.
  - IDLE, accept, MaxBurst==1: stay IDLE; owner<=grantee, rr_prio<=~grantee.
  - BUSY, accept: beat += 1. If beat+1==MaxBurst, go to IDLE with beat<=0.
  - BUSY, owner valid=0: go to IDLE with no write that cycle (one-cycle bubble); beat<=0.
  - BUSY, owner valid=1 and wfull=1: stay BUSY, beat held, no write.
- grant_id = owner in BUSY; the grantee in IDLE on accept; otherwise it holds its value.
- Simultaneous events: accept and a wq2_rptr change in the same cycle both enter the wfull compare for that cycle.
- Reset mid-burst returns all state to reset values immediately; any partial burst is abandoned.
- Producers must hold valid and data stable until accepted. No assertion checks this.

Test Plan:
- Reset: wrst_n=0 with both valid=1 -> both readies 0, mem_wclken 0, wptr 0, wfull 0. Release -> producer 0 granted first.
- Fill (AddrWidth=4), wq2_rptr=0, only req0_valid:
  - 16 writes at addresses 0..15.
  - wfull=1 after the 16th edge, wptr=5'b11000, req0_ready=0 thereafter.
- Contention, MaxBurst=4, both valid continuously, wq2_rptr tracking -> writes 0,0,0,0,1,1,1,1,0,... with grant_id following. Data lands at consecutive addresses, wrapping 15->0.
- Owner drop: producer 1 owns a burst and drops valid after 2 beats -> one bubble cycle, then producer 0 is granted. Producer 1 keeps priority for the next tie.
- Full release: array full and req1 stalled in BUSY; wq2_rptr goes 0->1 Gray -> wfull clears next cycle, the stalled beat is written to address 0, and beat count resumes.
- Reset mid-burst: pulse wrst_n low after 2 beats of producer 1 -> pointers 0, st=IDLE, rr_prio=0. The next tie is granted to producer 0.
